qpsk_symbol_upsampler: RTL and testbench
========================================

QPSK_SYMBOL_UPSAMPLER -- requirements
Module: qpsk_symbol_upsampler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the I/Q sample width (I in [31:16], Q in [15:0]).
REQ-002 SHALL have parameter SPS_W, default 4, meaning the width of the samples-per-symbol control.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sps  input  SPS_W  samples per symbol; 0 treated as 1.
REQ-006 SHALL have port zero_stuff  input  1  1 = zero-stuff replicas, 0 = hold symbol.
REQ-007 SHALL have port in_tdata  input  DATA_W  mapped QPSK symbol from the 32-to-2-bit converter.
REQ-008 SHALL have port in_tlast  input  1  symbol is the last of its packet.
REQ-009 SHALL have port in_tvalid  input  1  upstream symbol valid.
REQ-010 SHALL have port in_tready  output  1  block accepts a symbol this cycle.
REQ-011 SHALL have port out_tdata  output  DATA_W  upsampled sample.
REQ-012 SHALL have port out_tlast  output  1  last sample of a last-flagged symbol.
REQ-013 SHALL have port out_tvalid  output  1  output sample valid.
REQ-014 SHALL have port out_tready  input  1  downstream ready.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and EMIT; an input transfer is in_tvalid && in_tready, an output transfer is out_tvalid && out_tready.
REQ-016 SHALL, in IDLE, drive in_tready=1 and out_tvalid=0.
REQ-017 SHALL, on an input transfer, latch in_tdata, in_tlast, sps (0 mapped to 1) and zero_stuff into hold registers, clear rep_cnt, and enter EMIT on the next cycle.
REQ-018 SHALL have a latency of 1 cycle: out_tvalid=1 on the cycle after the accepting edge.
REQ-019 SHALL, in EMIT, drive out_tvalid=1 and out_tdata = held symbol when rep_cnt==0 or zero_stuff_lat==0, otherwise all zeros.
REQ-020 SHALL increment rep_cnt on each output transfer where rep_cnt < sps_lat-1.
REQ-021 SHALL treat an output transfer with rep_cnt == sps_lat-1 as the last replica.
REQ-022 SHALL drive in_tready in EMIT combinationally as out_tready && (rep_cnt == sps_lat-1), allowing back-to-back symbols without a bubble.
REQ-023 SHALL, on the last replica, reload from the input and stay in EMIT if an input transfer occurs in the same cycle; otherwise it SHALL return to IDLE.
REQ-024 SHALL drive out_tlast = tlast_lat && (rep_cnt == sps_lat-1) in EMIT, and 0 in IDLE.
REQ-025 SHALL hold out_tdata, out_tlast and out_tvalid stable while out_tvalid=1 and out_tready=0.
REQ-026 SHALL ignore changes to sps and zero_stuff until the next input transfer.
REQ-027 SHALL, with sps=1, sustain one output sample per cycle with in_tready tracking out_tready.

Reset
REQ-028 SHALL, on clk edge with reset=0, go to IDLE, clear rep_cnt and all hold registers, and drive out_tvalid=0, out_tlast=0, out_tdata=0 and in_tready=1 from the next cycle.
REQ-029 SHALL discard any symbol in progress on reset mid-operation, with no further replicas emitted.

Structure
REQ-030 SHALL take DATA_W, SPS_W, the IDLE/EMIT state encoding and the DAC level constants (ONE=16'h6665, ZERO=16'h999B) from a shared package qpsk_pkg, also used by the converter stage.
REQ-031 SHALL be a single flat module with no sub-module; the hold registers and counter are too small to justify one.

Verification
REQ-032 SHALL cover: sps=4, zero_stuff=0, symbol 0x6665_6665 with out_tready=1 -> four outputs 0x6665_6665 on consecutive cycles starting 1 cycle after accept, then in_tready=1.
REQ-033 SHALL cover: sps=4, zero_stuff=1, symbol 0x999B_6665 -> outputs 0x999B_6665, 0, 0, 0.
REQ-034 SHALL cover: sps=2, continuous in_tvalid with symbols A,B,C, out_tready=1 -> output A,A,B,B,C,C with no gap, and in_tready high only on the 2nd replica.
REQ-035 SHALL cover: sps=3, out_tready toggling 1,0,0,1,1 -> each sample held stable while stalled, exactly 3 samples delivered, and no input accepted early.
REQ-036 SHALL cover: sps=0, in_tlast=1 -> a single output with out_tlast=1; also sps changed from 2 to 5 mid-symbol -> the current symbol still emits 2 samples.
REQ-037 SHALL cover: reset=0 asserted at rep_cnt=1 of sps=4 -> next cycle out_tvalid=0 and in_tready=1, with no residual replicas after release.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK mapper/upsampler chain: widths, FSM encoding
// and the DAC levels used to map a bit onto an I or Q rail.
package qpsk_pkg;

    localparam int QPSK_DATA_W = 32;
    localparam int QPSK_SPS_W  = 4;

    localparam logic [15:0] ONE  = 16'h6665;
    localparam logic [15:0] ZERO = 16'h999B;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Map one data bit to its signed DAC level (used by the converter stage).
    function automatic logic [15:0] dac_level(input logic bit_val);
        return bit_val ? ONE : ZERO;
    endfunction

endpackage

// File: rtl/qpsk_symbol_upsampler.sv
// Repeats each accepted QPSK symbol sps times, either holding the symbol or
// zero-stuffing the replicas after the first, with AXI-stream style handshakes.
module qpsk_symbol_upsampler
    import qpsk_pkg::*;
#(
    parameter int DATA_W = QPSK_DATA_W,
    parameter int SPS_W  = QPSK_SPS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SPS_W-1:0]  sps,
    input  logic              zero_stuff,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tlast,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tlast,
    output logic              out_tvalid,
    input  logic              out_tready
);

    state_e             state_r;
    logic [DATA_W-1:0]  hold_data_r;
    logic               hold_last_r;
    logic               zero_stuff_r;
    logic [SPS_W-1:0]   last_idx_r;
    logic [SPS_W-1:0]   rep_cnt_r;
    logic [DATA_W-1:0]  out_tdata_r;
    logic               out_tlast_r;
    logic               out_tvalid_r;

    logic               in_tready_s;
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic               is_last_rep_s;
    logic [SPS_W-1:0]   new_last_idx_s;
    logic [SPS_W-1:0]   rep_cnt_inc_s;

    // A request of zero samples per symbol behaves as one.
    function automatic logic [SPS_W-1:0] sps_norm(input logic [SPS_W-1:0] s);
        return (s == {SPS_W{1'b0}}) ? SPS_W'(1) : s;
    endfunction

    // Handshake and replica-position decode.
    always_comb begin
        is_last_rep_s  = (rep_cnt_r == last_idx_r);
        new_last_idx_s = sps_norm(sps) - SPS_W'(1);
        rep_cnt_inc_s  = rep_cnt_r + SPS_W'(1);
        in_tready_s    = 1'b1;
        case (state_r)
            ST_IDLE: in_tready_s = 1'b1;
            ST_EMIT: in_tready_s = out_tready && is_last_rep_s;
            default: in_tready_s = 1'b1;
        endcase
        in_xfer_s  = in_tvalid && in_tready_s;
        out_xfer_s = out_tvalid_r && out_tready;
    end

    // Symbol hold registers, replica counter, FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            hold_data_r  <= {DATA_W{1'b0}};
            hold_last_r  <= 1'b0;
            zero_stuff_r <= 1'b0;
            last_idx_r   <= {SPS_W{1'b0}};
            rep_cnt_r    <= {SPS_W{1'b0}};
            out_tdata_r  <= {DATA_W{1'b0}};
            out_tlast_r  <= 1'b0;
            out_tvalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_xfer_s) begin
                        state_r      <= ST_EMIT;
                        hold_data_r  <= in_tdata;
                        hold_last_r  <= in_tlast;
                        zero_stuff_r <= zero_stuff;
                        last_idx_r   <= new_last_idx_s;
                        rep_cnt_r    <= {SPS_W{1'b0}};
                        out_tdata_r  <= in_tdata;
                        out_tlast_r  <= in_tlast && (new_last_idx_s == {SPS_W{1'b0}});
                        out_tvalid_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (out_xfer_s && is_last_rep_s) begin
                        // Reloading here keeps back-to-back symbols bubble-free.
                        if (in_xfer_s) begin
                            state_r      <= ST_EMIT;
                            hold_data_r  <= in_tdata;
                            hold_last_r  <= in_tlast;
                            zero_stuff_r <= zero_stuff;
                            last_idx_r   <= new_last_idx_s;
                            rep_cnt_r    <= {SPS_W{1'b0}};
                            out_tdata_r  <= in_tdata;
                            out_tlast_r  <= in_tlast && (new_last_idx_s == {SPS_W{1'b0}});
                            out_tvalid_r <= 1'b1;
                        end else begin
                            state_r      <= ST_IDLE;
                            rep_cnt_r    <= {SPS_W{1'b0}};
                            out_tdata_r  <= {DATA_W{1'b0}};
                            out_tlast_r  <= 1'b0;
                            out_tvalid_r <= 1'b0;
                        end
                    end else if (out_xfer_s) begin
                        rep_cnt_r    <= rep_cnt_inc_s;
                        out_tdata_r  <= zero_stuff_r ? {DATA_W{1'b0}} : hold_data_r;
                        out_tlast_r  <= hold_last_r && (rep_cnt_inc_s == last_idx_r);
                    end else begin
                        rep_cnt_r    <= rep_cnt_r;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    rep_cnt_r    <= {SPS_W{1'b0}};
                    out_tdata_r  <= {DATA_W{1'b0}};
                    out_tlast_r  <= 1'b0;
                    out_tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_tready  = in_tready_s;
    assign out_tdata  = out_tdata_r;
    assign out_tlast  = out_tlast_r;
    assign out_tvalid = out_tvalid_r;

endmodule

// File: tb/tb_qpsk_symbol_upsampler.sv
// Directed scoreboard bench for qpsk_symbol_upsampler: expected replicas are
// queued at symbol acceptance and popped on every output transfer.
module tb_qpsk_symbol_upsampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sps;
    logic        zero_stuff;
    logic [31:0] in_tdata;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [32:0] exp_q[$];

    qpsk_symbol_upsampler dut (
        .clk        (clk),
        .reset      (reset),
        .sps        (sps),
        .zero_stuff (zero_stuff),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: scores any output transfer against the queue.
    task automatic monitor();
        logic [32:0] e;
        if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_tdata), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("out_tdata", 64'(out_tdata), 64'(e[31:0]));
                check("out_tlast", 64'(out_tlast), 64'(e[32]));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Offer a symbol until accepted, then queue the replicas it must produce.
    task automatic accept(input logic [31:0] d, input logic l, input logic [3:0] s,
                          input logic z, output int waited);
        int n;
        logic done;
        in_tdata = d; in_tlast = l; sps = s; zero_stuff = z; in_tvalid = 1'b1;
        waited = 0; done = 1'b0;
        while (!done && waited < 64) begin
            @(negedge clk);
            monitor();
            done = in_tready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_tvalid = 1'b0;
        if (!done) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            n = (s == 4'd0) ? 1 : int'(s);
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({l && (i == n - 1), (z && i > 0) ? 32'h0 : d});
            end
        end
    endtask

    // Expect n consecutive valid output cycles.
    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, 64'(out_tvalid), 64'd1);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_tvalid), 64'd0);
        check({tag, "_ready"}, 64'(in_tready), 64'd1);
        check({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [31:0] held;
        logic [4:0]  stall_rdy;
        logic [4:0]  stall_inr;

        reset = 1'b0; sps = 4'd1; zero_stuff = 1'b0; in_tdata = 32'h0;
        in_tlast = 1'b0; in_tvalid = 1'b0; out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 64'(out_tvalid), 64'd0);
        check("rst_last",  64'(out_tlast),  64'd0);
        check("rst_data",  64'(out_tdata),  64'd0);
        check("rst_ready", 64'(in_tready),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc();

        // sps=4 hold: four copies, first one cycle after accept
        accept(32'h6665_6665, 1'b0, 4'd4, 1'b0, w);
        drain(3, "hold_valid");
        @(negedge clk);
        check("hold_valid", 64'(out_tvalid), 64'd1);
        check("hold_last_ready", 64'(in_tready), 64'd1);
        monitor();
        @(posedge clk);
        #1;
        expect_idle("hold_end");

        // sps=4 zero-stuff
        accept(32'h999B_6665, 1'b0, 4'd4, 1'b1, w);
        drain(4, "zs_valid");
        expect_idle("zs_end");

        // sps=2 back-to-back A,B,C: B and C wait exactly for the 2nd replica
        accept(32'h1111_AAAA, 1'b0, 4'd2, 1'b0, w);
        accept(32'h2222_BBBB, 1'b0, 4'd2, 1'b0, w);
        check("b2b_wait_b", 64'(w), 64'd2);
        accept(32'h3333_CCCC, 1'b1, 4'd2, 1'b0, w);
        check("b2b_wait_c", 64'(w), 64'd2);
        drain(2, "b2b_valid");
        expect_idle("b2b_end");

        // sps=3 with out_tready 1,0,0,1,1
        accept(32'h5A5A_A5A5, 1'b1, 4'd3, 1'b0, w);
        stall_rdy = 5'b11001;
        stall_inr = 5'b10000;
        held = 32'h0;
        for (int i = 0; i < 5; i++) begin
            out_tready = stall_rdy[i];
            @(negedge clk);
            check("stall_valid", 64'(out_tvalid), 64'd1);
            check("stall_in_ready", 64'(in_tready), 64'(stall_inr[i]));
            if (i == 2 || i == 3) check("stall_stable", 64'(out_tdata), 64'(held));
            held = out_tdata;
            monitor();
            @(posedge clk);
            #1;
        end
        out_tready = 1'b1;
        expect_idle("stall_end");

        // sps=0 acts as 1, tlast on the single sample
        accept(32'h6665_999B, 1'b1, 4'd0, 1'b0, w);
        @(negedge clk);
        check("sps0_last", 64'(out_tlast), 64'd1);
        monitor();
        @(posedge clk);
        #1;
        expect_idle("sps0_end");

        // sps changed mid-symbol is ignored
        accept(32'h0F0F_F0F0, 1'b0, 4'd2, 1'b1, w);
        sps = 4'd5;
        zero_stuff = 1'b0;
        drain(2, "spschg_valid");
        expect_idle("spschg_end");

        // reset at rep_cnt=1 of sps=4 discards the symbol
        accept(32'h1234_5678, 1'b0, 4'd4, 1'b0, w);
        cyc();
        out_tready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", 64'(out_tvalid), 64'd0);
        check("midrst_ready", 64'(in_tready),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_replica", 64'(out_tvalid), 64'd0);
            monitor();
            @(posedge clk);
            #1;
        end

        check("final_qempty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
